// File: rtl/cnn_weight_loader_if.sv
// Command, byte-stream handshake and weight-memory write bus of the CNN weight loader.
// Prefixes are from the loader's side: i_ flows into the loader, o_ flows out of it.
interface cnn_weight_loader_if #(
  parameter int KERNEL_SIZE      = 4,
  parameter int NUM_FEATURES     = 3,
  parameter int FLATTENED_LENGTH = 432,
  parameter int DATA_WIDTH       = 8
);
  localparam int CHUNK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_BIAS  = NUM_FEATURES + 1;
  localparam int FC_WRITES = FLATTENED_LENGTH / CHUNK;
  localparam int FEAT_AW   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int FC_AW     = (FC_WRITES > 1) ? $clog2(FC_WRITES) : 1;

  logic                                i_load_start;
  logic                                i_run_start;
  logic [DATA_WIDTH-1:0]               i_byte_in;
  logic                                i_byte_valid;
  logic                                o_byte_ready;
  logic [CHUNK-1:0][DATA_WIDTH-1:0]    o_feature_weights_input;
  logic [FEAT_AW-1:0]                  o_feature_writeAddr;
  logic                                o_feature_WrEn;
  logic [CHUNK-1:0][DATA_WIDTH-1:0]    o_fullyconnected_weights_input;
  logic [FC_AW-1:0]                    o_fullyconnected_writeAddr;
  logic                                o_fullyconnected_WrEn;
  logic [NUM_BIAS-1:0][DATA_WIDTH-1:0] o_bias_weights_input;
  logic                                o_bias_WrEn;
  logic                                o_convolution_enable;
  logic                                o_busy;
  logic                                o_result_valid;
  logic                                o_cmd_err;

  modport master (
    output i_load_start, i_run_start, i_byte_in, i_byte_valid,
    input  o_byte_ready, o_feature_weights_input, o_feature_writeAddr, o_feature_WrEn,
           o_fullyconnected_weights_input, o_fullyconnected_writeAddr, o_fullyconnected_WrEn,
           o_bias_weights_input, o_bias_WrEn, o_convolution_enable, o_busy, o_result_valid,
           o_cmd_err
  );

  modport slave (
    input  i_load_start, i_run_start, i_byte_in, i_byte_valid,
    output o_byte_ready, o_feature_weights_input, o_feature_writeAddr, o_feature_WrEn,
           o_fullyconnected_weights_input, o_fullyconnected_writeAddr, o_fullyconnected_WrEn,
           o_bias_weights_input, o_bias_WrEn, o_convolution_enable, o_busy, o_result_valid,
           o_cmd_err
  );
endinterface

// File: rtl/cnn_weight_loader.sv
// Byte-serial weight loader and run sequencer for the CNN core: assembles 16-byte chunks,
// strobes the feature/FC/bias memories, then kicks the core and times the run.
module cnn_weight_loader #(
  parameter int KERNEL_SIZE      = 4,
  parameter int NUM_FEATURES     = 3,
  parameter int FLATTENED_LENGTH = 432,
  parameter int DATA_WIDTH       = 8,
  parameter int RUN_LATENCY      = 632
) (
  input logic                clk,
  input logic                rst,
  cnn_weight_loader_if.slave bus
);
  localparam int CHUNK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NUM_BIAS  = NUM_FEATURES + 1;
  localparam int FC_WRITES = FLATTENED_LENGTH / CHUNK;
  localparam int FEAT_AW   = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int FC_AW     = (FC_WRITES > 1) ? $clog2(FC_WRITES) : 1;
  localparam int IDX_W     = $clog2(CHUNK);
  localparam int RUN_W     = $clog2(RUN_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_FEAT, S_FC, S_BIAS, S_KICK, S_RUN, S_DONE
  } state_t;

  state_t                              r_state;
  state_t                              w_next_state;
  logic                                r_in_write;
  logic [IDX_W-1:0]                    r_byte_idx;
  logic [CHUNK-2:0][DATA_WIDTH-1:0]    r_asm;
  logic [CHUNK-1:0][DATA_WIDTH-1:0]    r_feat_data;
  logic [CHUNK-1:0][DATA_WIDTH-1:0]    r_fc_data;
  logic [NUM_BIAS-1:0][DATA_WIDTH-1:0] r_bias_data;
  logic [FEAT_AW-1:0]                  r_feat_addr;
  logic [FC_AW-1:0]                    r_fc_addr;
  logic [RUN_W-1:0]                    r_run_cnt;
  logic                                r_loaded;
  logic                                r_cmd_err;

  logic             w_cmd_idle;
  logic             w_load_go;
  logic             w_run_go;
  logic             w_reject;
  logic             w_loading;
  logic             w_accept;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_last_byte;
  logic             w_write;
  logic             w_last_write;

  // Commands are only honoured between runs; load_start has priority over run_start.
  assign w_cmd_idle  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_load_go   = w_cmd_idle && bus.i_load_start;
  assign w_run_go    = w_cmd_idle && !bus.i_load_start && bus.i_run_start && r_loaded;
  assign w_reject    = (bus.i_load_start || bus.i_run_start) && !w_load_go && !w_run_go;

  assign w_loading   = (r_state == S_FEAT) || (r_state == S_FC) || (r_state == S_BIAS);
  assign w_accept    = w_loading && !r_in_write && bus.i_byte_valid;
  assign w_last_idx  = (r_state == S_BIAS) ? IDX_W'(NUM_BIAS - 1) : IDX_W'(CHUNK - 1);
  assign w_last_byte = w_accept && (r_byte_idx == w_last_idx);
  assign w_write     = w_loading && r_in_write;
  assign w_last_write = (r_state == S_FEAT) ? (r_feat_addr == FEAT_AW'(NUM_FEATURES - 1)) :
                        (r_state == S_FC)   ? (r_fc_addr == FC_AW'(FC_WRITES - 1)) : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_load_go)     w_next_state = S_FEAT;
        else if (w_run_go) w_next_state = S_KICK;
      end
      S_FEAT:  if (w_write && w_last_write) w_next_state = S_FC;
      S_FC:    if (w_write && w_last_write) w_next_state = S_BIAS;
      S_BIAS:  if (w_write) w_next_state = S_KICK;
      S_KICK:  w_next_state = S_RUN;
      S_RUN:   if (r_run_cnt == RUN_W'(RUN_LATENCY - 1)) w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The last byte of a chunk is merged straight into the output bus register, so the
  // bus is stable through the write cycle and holds afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_write  <= 1'b0;
      r_byte_idx  <= '0;
      r_asm       <= '0;
      r_feat_data <= '0;
      r_fc_data   <= '0;
      r_bias_data <= '0;
      r_feat_addr <= '0;
      r_fc_addr   <= '0;
      r_run_cnt   <= '0;
      r_loaded    <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err <= w_reject;
      if (w_load_go) begin
        r_loaded    <= 1'b0;
        r_feat_addr <= '0;
        r_fc_addr   <= '0;
        r_byte_idx  <= '0;
        r_in_write  <= 1'b0;
      end
      if (w_accept) begin
        if (w_last_byte) begin
          r_byte_idx <= '0;
          r_in_write <= 1'b1;
          case (r_state)
            S_FEAT:  r_feat_data <= {bus.i_byte_in, r_asm};
            S_FC:    r_fc_data   <= {bus.i_byte_in, r_asm};
            default: r_bias_data <= {bus.i_byte_in, r_asm[NUM_BIAS-2:0]};
          endcase
        end else begin
          r_asm[r_byte_idx] <= bus.i_byte_in;
          r_byte_idx        <= r_byte_idx + 1'b1;
        end
      end
      if (w_write) begin
        r_in_write <= 1'b0;
        if (r_state == S_FEAT && !w_last_write) r_feat_addr <= r_feat_addr + 1'b1;
        if (r_state == S_FC && !w_last_write)   r_fc_addr   <= r_fc_addr + 1'b1;
        if (r_state == S_BIAS)                  r_loaded    <= 1'b1;
      end
      if (r_state == S_KICK)     r_run_cnt <= RUN_W'(1);
      else if (r_state == S_RUN) r_run_cnt <= r_run_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.o_byte_ready                   = w_loading && !r_in_write;
    bus.o_feature_WrEn                 = !(w_write && (r_state == S_FEAT));
    bus.o_fullyconnected_WrEn          = !(w_write && (r_state == S_FC));
    bus.o_bias_WrEn                    = !(w_write && (r_state == S_BIAS));
    bus.o_feature_writeAddr            = r_feat_addr;
    bus.o_fullyconnected_writeAddr     = r_fc_addr;
    bus.o_feature_weights_input        = r_feat_data;
    bus.o_fullyconnected_weights_input = r_fc_data;
    bus.o_bias_weights_input           = r_bias_data;
    bus.o_convolution_enable           = (r_state != S_KICK);
    bus.o_busy                         = !w_cmd_idle;
    bus.o_result_valid                 = (r_state == S_DONE);
    bus.o_cmd_err                      = r_cmd_err;
  end
endmodule

// File: tb/tb_cnn_weight_loader.sv
// Self-checking bench for cnn_weight_loader: directed command sequence with random byte
// values and random valid gaps, checked against a byte-stream model of the memory writes.
module tb_cnn_weight_loader;
  localparam int NBYTES = 484;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checkCount = 0;
  int   errorCount = 0;

  cnn_weight_loader_if bus ();
  cnn_weight_loader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   stream[$];
  int           featCyc[$];
  logic [1:0]   featAddr[$];
  logic [127:0] featData[$];
  int           fcCyc[$];
  logic [4:0]   fcAddr[$];
  logic [127:0] fcData[$];
  int           biasCyc[$];
  logic [31:0]  biasData[$];
  int           kickCyc[$];
  int           errCyc[$];
  int           rvCyc[$];
  int           readyInWrite = 0;
  logic         prevRv = 1'b0;

  // Records every strobe and status event with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.o_feature_WrEn === 1'b0) begin
      featCyc.push_back(cyc);
      featAddr.push_back(bus.o_feature_writeAddr);
      featData.push_back(bus.o_feature_weights_input);
      if (bus.o_byte_ready !== 1'b0) readyInWrite++;
    end
    if (bus.o_fullyconnected_WrEn === 1'b0) begin
      fcCyc.push_back(cyc);
      fcAddr.push_back(bus.o_fullyconnected_writeAddr);
      fcData.push_back(bus.o_fullyconnected_weights_input);
      if (bus.o_byte_ready !== 1'b0) readyInWrite++;
    end
    if (bus.o_bias_WrEn === 1'b0) begin
      biasCyc.push_back(cyc);
      biasData.push_back(bus.o_bias_weights_input);
      if (bus.o_byte_ready !== 1'b0) readyInWrite++;
    end
    if (bus.o_convolution_enable === 1'b0) kickCyc.push_back(cyc);
    if (bus.o_cmd_err === 1'b1) errCyc.push_back(cyc);
    if (bus.o_result_valid === 1'b1 && prevRv !== 1'b1) rvCyc.push_back(cyc);
    prevRv = bus.o_result_valid;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMon();
    featCyc.delete(); featAddr.delete(); featData.delete();
    fcCyc.delete(); fcAddr.delete(); fcData.delete();
    biasCyc.delete(); biasData.delete();
    kickCyc.delete(); errCyc.delete(); rvCyc.delete();
    readyInWrite = 0;
  endtask

  task automatic genStream(input bit randomBytes);
    stream.delete();
    for (int i = 0; i < NBYTES; i++)
      stream.push_back(randomBytes ? 8'($urandom) : 8'(i + 1));
  endtask

  function automatic logic [127:0] expChunk(input int offset);
    logic [127:0] e = '0;
    for (int k = 0; k < 16; k++) e[8*k +: 8] = stream[offset + k];
    return e;
  endfunction

  function automatic logic [31:0] expBias(input int offset);
    logic [31:0] e = '0;
    for (int k = 0; k < 4; k++) e[8*k +: 8] = stream[offset + k];
    return e;
  endfunction

  // Streams stream[0..n-1] with valid asserted at the given duty; a presented byte is held until taken.
  task automatic applyStimulus(input int duty, input int n, input int budget, input int pokeIdx,
                               output int sent, output int pokeCyc);
    int idx = 0;
    bit took = 1'b0;
    bit poked = 1'b0;
    pokeCyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (took) idx++;
      bus.i_load_start = 1'b0;
      if (idx >= n) break;
      if (!poked && idx == pokeIdx) begin
        bus.i_load_start = 1'b1;
        poked = 1'b1;
        pokeCyc = cyc;
      end
      if (took || !bus.i_byte_valid) bus.i_byte_valid = ($urandom_range(0, 99) < 32'(duty));
      bus.i_byte_in = stream[idx];
      took = bus.i_byte_valid && bus.o_byte_ready;
      @(negedge clk);
    end
    bus.i_byte_valid = 1'b0;
    sent = idx;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ctrl"}, 256'({bus.o_feature_WrEn, bus.o_fullyconnected_WrEn, bus.o_bias_WrEn,
                bus.o_convolution_enable, bus.o_byte_ready, bus.o_busy, bus.o_result_valid,
                bus.o_cmd_err}), 256'(8'b1111_0000));
    checkOutput({tag, " addr"}, 256'({bus.o_feature_writeAddr, bus.o_fullyconnected_writeAddr}), 256'(0));
    checkOutput({tag, " featData"}, 256'(bus.o_feature_weights_input), 256'(0));
    checkOutput({tag, " fcData"}, 256'(bus.o_fullyconnected_weights_input), 256'(0));
    checkOutput({tag, " biasData"}, 256'(bus.o_bias_weights_input), 256'(0));
  endtask

  // Memory writes must be exactly the stream cut into 3 feature, 27 FC and 1 bias chunk, in order.
  task automatic checkLoad(input string tag, input bit timed, input int base);
    checkOutput({tag, " featN"}, 256'(featCyc.size()), 256'(3));
    for (int f = 0; f < featCyc.size() && f < 3; f++) begin
      checkOutput($sformatf("%s feat%0d addr", tag, f), 256'(featAddr[f]), 256'(f));
      checkOutput($sformatf("%s feat%0d data", tag, f), 256'(featData[f]), 256'(expChunk(16 * f)));
      if (timed) checkOutput($sformatf("%s feat%0d cycle", tag, f), 256'(featCyc[f] - base), 256'(17 * (f + 1)));
    end
    checkOutput({tag, " fcN"}, 256'(fcCyc.size()), 256'(27));
    for (int c = 0; c < fcCyc.size() && c < 27; c++) begin
      checkOutput($sformatf("%s fc%0d addr", tag, c), 256'(fcAddr[c]), 256'(c));
      checkOutput($sformatf("%s fc%0d data", tag, c), 256'(fcData[c]), 256'(expChunk(48 + 16 * c)));
      if (timed) checkOutput($sformatf("%s fc%0d cycle", tag, c), 256'(fcCyc[c] - base), 256'(51 + 17 * (c + 1)));
    end
    checkOutput({tag, " biasN"}, 256'(biasCyc.size()), 256'(1));
    if (biasCyc.size() > 0) begin
      checkOutput({tag, " bias data"}, 256'(biasData[0]), 256'(expBias(480)));
      if (timed) checkOutput({tag, " bias cycle"}, 256'(biasCyc[0] - base), 256'(515));
    end
    checkOutput({tag, " ready in write"}, 256'(readyInWrite), 256'(0));
  endtask

  task automatic waitRv(input int budget);
    for (int c = 0; c < budget && rvCyc.size() == 0; c++) @(negedge clk);
  endtask

  task automatic checkRun(input string tag, input int kickRel, input int base);
    checkOutput({tag, " kickN"}, 256'(kickCyc.size()), 256'(1));
    checkOutput({tag, " rvN"}, 256'(rvCyc.size()), 256'(1));
    if (kickCyc.size() > 0 && rvCyc.size() > 0) begin
      if (kickRel >= 0) checkOutput({tag, " kick cycle"}, 256'(kickCyc[0] - base), 256'(kickRel));
      checkOutput({tag, " run latency"}, 256'(rvCyc[0] - kickCyc[0]), 256'(632));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, sent, pokeCyc;
    rst = 1'b1;
    bus.i_load_start = 1'b0;
    bus.i_run_start  = 1'b0;
    bus.i_byte_in    = 8'h00;
    bus.i_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    $display("[TB] run_start without weights");
    clearMon();
    bus.i_run_start = 1'b1;
    @(negedge clk);
    bus.i_run_start = 1'b0;
    checkOutput("noWeights cmd_err", 256'(bus.o_cmd_err), 256'(1));
    checkOutput("noWeights busy", 256'({bus.o_busy, bus.o_convolution_enable}), 256'(2'b01));
    @(negedge clk);
    checkOutput("noWeights cmd_err pulse", 256'(bus.o_cmd_err), 256'(0));
    repeat (5) @(negedge clk);
    checkOutput("noWeights strobes", 256'(featCyc.size() + fcCyc.size() + biasCyc.size() + kickCyc.size()), 256'(0));

    $display("[TB] full load, valid held high, load_start poked during FC");
    genStream(1'b0);
    clearMon();
    base = cyc;
    bus.i_load_start = 1'b1;
    @(negedge clk);
    bus.i_load_start = 1'b0;
    checkOutput("load1 busy", 256'({bus.o_busy, bus.o_byte_ready}), 256'(2'b11));
    applyStimulus(100, NBYTES, 3000, 100, sent, pokeCyc);
    checkOutput("load1 bytes sent", 256'(sent), 256'(NBYTES));
    waitRv(2000);
    checkLoad("load1", 1'b1, base);
    checkRun("load1", 516, base);
    checkOutput("load1 errN", 256'(errCyc.size()), 256'(1));
    if (errCyc.size() > 0) checkOutput("load1 poke err cycle", 256'(errCyc[0]), 256'(pokeCyc + 1));

    $display("[TB] run_start in DONE");
    clearMon();
    base = cyc;
    bus.i_run_start = 1'b1;
    @(negedge clk);
    bus.i_run_start = 1'b0;
    checkOutput("rerun kick state", 256'({bus.o_convolution_enable, bus.o_result_valid, bus.o_busy}), 256'(3'b001));
    waitRv(2000);
    checkRun("rerun", 1, base);
    checkOutput("rerun rv cycle", 256'(rvCyc.size() > 0 ? rvCyc[0] - base : -1), 256'(633));
    checkOutput("rerun no writes", 256'(featCyc.size() + fcCyc.size() + biasCyc.size()), 256'(0));
    checkOutput("rerun errN", 256'(errCyc.size()), 256'(0));

    $display("[TB] both commands in DONE, 50%% valid gaps");
    clearMon();
    bus.i_load_start = 1'b1;
    bus.i_run_start  = 1'b1;
    @(negedge clk);
    bus.i_load_start = 1'b0;
    bus.i_run_start  = 1'b0;
    checkOutput("both loads", 256'({bus.o_busy, bus.o_byte_ready, bus.o_convolution_enable, bus.o_result_valid}), 256'(4'b1110));
    applyStimulus(50, NBYTES, 4000, -1, sent, pokeCyc);
    checkOutput("gaps bytes sent", 256'(sent), 256'(NBYTES));
    waitRv(2000);
    checkLoad("gaps", 1'b0, 0);
    checkRun("gaps", -1, 0);
    checkOutput("gaps errN", 256'(errCyc.size()), 256'(0));

    $display("[TB] reset on the 200th byte");
    genStream(1'b1);
    clearMon();
    bus.i_load_start = 1'b1;
    @(negedge clk);
    bus.i_load_start = 1'b0;
    applyStimulus(100, 199, 1000, -1, sent, pokeCyc);
    checkOutput("midload bytes sent", 256'(sent), 256'(199));
    bus.i_byte_in    = stream[199];
    bus.i_byte_valid = 1'b1;
    #2 rst = 1'b1;
    #1 checkResetState("async rst");
    @(negedge clk);
    checkResetState("rst held");
    rst = 1'b0;
    bus.i_byte_valid = 1'b0;
    @(negedge clk);
    clearMon();
    bus.i_run_start = 1'b1;
    @(negedge clk);
    bus.i_run_start = 1'b0;
    checkOutput("postRst run rejected", 256'({bus.o_cmd_err, bus.o_busy}), 256'(2'b10));

    $display("[TB] full random load after reset");
    clearMon();
    bus.i_load_start = 1'b1;
    @(negedge clk);
    bus.i_load_start = 1'b0;
    applyStimulus(50, NBYTES, 4000, -1, sent, pokeCyc);
    checkOutput("reload bytes sent", 256'(sent), 256'(NBYTES));
    waitRv(2000);
    checkLoad("reload", 1'b0, 0);
    checkRun("reload", -1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end
endmodule
